// File: rtl/div_seq_r0_pkg.sv
// div_seq_r0_pkg: shared state/special-case encodings and constants for the sequential divider
package div_seq_r0_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam logic [DEF_DATA_WIDTH-1:0] MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    typedef enum logic [1:0] {NONE, DIV0, OVF} special_t;

endpackage

// File: rtl/div_seq_r0_step.sv
// div_step_r0: one combinational restoring-division step on {rem, quo}
module div_step_r0 #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_nxt,
    output logic [W-1:0] quo_nxt
);

    logic [W:0] shifted;
    logic [W:0] trial;

    // rem < divisor always holds, so the shifted value fits W+1 bits and trial[W] is the borrow
    always_comb begin
        shifted = {rem, quo[W-1]};
        trial   = shifted - {1'b0, divisor};
        rem_nxt = trial[W] ? shifted[W-1:0] : trial[W-1:0];
        quo_nxt = {quo[W-2:0], ~trial[W]};
    end

endmodule

// File: rtl/div_seq_r0.sv
// div_seq_r0: multi-cycle signed/unsigned divider returning {remainder, quotient} and C/Z/V/S flags
module div_seq_r0
    import div_seq_r0_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    signed_op,
    input  logic [DATA_WIDTH-1:0]   input1,
    input  logic [DATA_WIDTH-1:0]   input2,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] dataOut,
    output logic                    C,
    output logic                    Z,
    output logic                    V,
    output logic                    S
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MIN_W = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                state, state_nxt;
    special_t              special, special_in;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] rem, quo, dvs, dvd;
    logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;
    logic [DATA_WIDTH-1:0] mag1, mag2, q_fin, r_fin;
    logic                  sign_q, sign_r, accept;

    div_step_r0 #(.W(DATA_WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvs),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // operand magnitudes, special-case detection and final sign-corrected results
    always_comb begin
        accept     = (state == IDLE) && start;
        mag1       = (signed_op && input1[DATA_WIDTH-1]) ? -input1 : input1;
        mag2       = (signed_op && input2[DATA_WIDTH-1]) ? -input2 : input2;
        special_in = (input2 == '0) ? DIV0 :
                     (signed_op && input1 == MIN_W && input2 == '1) ? OVF : NONE;
        q_fin      = (special == DIV0) ? '1 : (special == OVF) ? MIN_W : sign_q ? -quo : quo;
        r_fin      = (special == DIV0) ? dvd : (special == OVF) ? '0 : sign_r ? -rem : rem;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic: specials skip the iteration and go straight to FIX
    always_comb begin
        state_nxt = (state == IDLE) ? (accept ? ((special_in != NONE) ? FIX : RUN) : IDLE) :
                    (state == RUN)  ? ((cnt == CW'(1)) ? FIX : RUN) :
                    (state == FIX)  ? DONE : IDLE;
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        C    = 1'b0;
    end

    // datapath: capture on accept, iterate in RUN, publish result and flags in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            dvd     <= '0;
            cnt     <= '0;
            special <= NONE;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dataOut <= '0;
            Z       <= 1'b0;
            V       <= 1'b0;
            S       <= 1'b0;
        end else begin
            if (accept) begin
                rem     <= '0;
                quo     <= mag1;
                dvs     <= mag2;
                dvd     <= input1;
                cnt     <= CW'(DATA_WIDTH);
                special <= special_in;
                sign_q  <= signed_op & (input1[DATA_WIDTH-1] ^ input2[DATA_WIDTH-1]);
                sign_r  <= signed_op & input1[DATA_WIDTH-1];
            end
            if (state == RUN) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt - CW'(1);
            end
            if (state == FIX) begin
                dataOut <= {r_fin, q_fin};
                Z       <= (q_fin == '0);
                V       <= (special != NONE);
                S       <= q_fin[DATA_WIDTH-1];
            end
        end
    end

endmodule

// File: doc/div_seq_r0.md
Name: div_seq_r0

Overview:
- Multi-cycle iterative integer divider, the inverse of the datapath multiplier.
- Produces quotient and remainder packed as {HI = remainder, LO = quotient} for the MIPS DIV/DIVU path.
- Flags C/Z/V/S use the same convention as the multiplier.
- Sits beside the ALU/multiplier in EX; the hazard unit stalls the pipeline while busy is high.

Parameters:
- DATA_WIDTH, 32, operand width; result bus is 2*DATA_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- signed_op  in  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
- input1  in  DATA_WIDTH  dividend, captured with start.
- input2  in  DATA_WIDTH  divisor, captured with start.
- busy  out  1  high in RUN, FIX and DONE.
- done  out  1  one-cycle pulse, result valid.
- dataOut  out  2*DATA_WIDTH  {remainder, quotient}, held until the next accepted start.
- C  out  1  always 0.
- Z  out  1  quotient == 0.
- V  out  1  divide-by-zero, or signed overflow (most-negative / -1).
- S  out  1  quotient MSB.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; busy=0, done=0, dataOut=0, C=Z=V=S=0; counter, working registers and sign flags all 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at edge N captures operands and signed_op.
  - If divisor==0 -> FIX with special=DIV0.
  - Else if signed_op and dividend==MIN and divisor==-1 -> FIX with special=OVF.
  - Else -> RUN with counter=DATA_WIDTH.
  - Operands are converted to magnitudes when signed_op=1; sign_q = sign1^sign2 and sign_r = sign1 are recorded.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left 1.
  - trial = rem - divisor_mag, computed in DATA_WIDTH+1 bits.
  - If trial is non-negative, rem = trial and the quotient LSB = 1.
  - counter decrements; at counter==1 -> FIX.
  - Takes exactly DATA_WIDTH cycles.
- FIX: applies sign correction (negate quotient if sign_q, negate remainder if sign_r, signed only) or the special result, registers dataOut and flags, then -> DONE.
  - DIV0: quotient = all ones, remainder = dividend as given, V=1.
  - OVF: quotient = MIN, remainder = 0, V=1.
- DONE: done=1 for exactly one cycle, then -> IDLE. done is a registered output equal to (state==DONE).
- Latency, for start sampled at edge N:
  - Normal: done high in cycle N+DATA_WIDTH+2.
  - Special cases: done high in cycle N+2.
- start while busy is ignored, including during DONE; the earliest new start is accepted the cycle after done.
- Operands changing while busy have no effect.
- dataOut and flags update only in FIX.
- Flags are computed on the final, sign-corrected quotient. Z and S are computed normally in the special cases: DIV0 gives Z=0, S=1.
- Signed remainder sign follows the dividend; |remainder| < |divisor|.
- rst_n asserted mid-operation aborts immediately to the reset values; no done is issued.

Decomposition:
- Shared package/include (div_defs): state encodings IDLE/RUN/FIX/DONE, special-case codes NONE/DIV0/OVF, localparam MIN = 1 followed by zeros.
- One natural sub-module: div_step_r0, a combinational single restoring step. Inputs rem, quo, divisor; outputs next rem and quo. Instantiated once in RUN.
- Counter width is $clog2(DATA_WIDTH+1).

Test Plan:
- Unsigned 100 / 7, start at cycle 0 -> done pulse at cycle 34 only; dataOut = {0x00000002, 0x0000000E}; Z=0, V=0, S=0, C=0; busy high cycles 1-34.
- Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, S=1, V=0; same operands with signed_op=0 -> quotient 0x7FFFFFFC, remainder 0x00000001.
- 5 / 0 (either mode) -> done at cycle 2; quotient 0xFFFFFFFF, remainder 0x00000005, V=1.
- Signed 0x80000000 / 0xFFFFFFFF -> done at cycle 2; quotient 0x80000000, remainder 0, V=1, S=1.
- Unsigned 3 / 9 -> quotient 0, remainder 3, Z=1. start pulsed again at cycles 5 and 34 -> both ignored, exactly one done. A new start at cycle 35 is accepted.
- Start 100/7, drop rst_n at cycle 10 for 2 cycles -> busy=0, done=0 and dataOut=0 immediately. No done for the aborted op. A subsequent 50/5 returns quotient 10, remainder 0.
